// File: rtl/jogador_automatico.sv
// Automatic player: drives timed plays into the game circuit from its expected-play output.
// Outputs decoded from state/registers only; optional macro JOGADOR_INJETA_ERRO_EN adds deliberate wrong play.
// No backpressure: the game circuit is observed through acertou/errou/pronto flags.
module jogador_automatico #(
    parameter int HOLD_CYCLES  = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int START_CYCLES = 5,
    parameter int N_JOGADAS    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       comecar,
    input  logic [3:0] memoria,
    input  logic       acertou,
    input  logic       errou,
    input  logic       pronto,
`ifdef JOGADOR_INJETA_ERRO_EN
    input  logic [4:0] erro_rodada,
`endif
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic       ocupado,
    output logic       fim_ok,
    output logic       fim_erro,
    output logic [4:0] jogadas_feitas,
    output logic [3:0] db_estado
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_HG > START_CYCLES) ? MAX_HG : START_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PULSO_INICIAR = 4'd1,
        ESPERA        = 4'd2,
        APLICA        = 4'd3,
        INTERVALO     = 4'd4,
        VERIFICA      = 4'd5,
        FIM_OK        = 4'd6,
        FIM_ERRO      = 4'd7,
        ERRO_ENTRADA  = 4'd8
    } estado_t;

    estado_t       estado, prox;
    logic [CW-1:0] cnt;
    logic [3:0]    mem_q;
    logic [4:0]    jog_q;
    logic          mem_onehot;
    logic [3:0]    jogada;

    assign mem_onehot = (mem_q != 4'b0000) && ((mem_q & (mem_q - 4'd1)) == 4'b0000);

`ifdef JOGADOR_INJETA_ERRO_EN
    logic inj_q;
    assign jogada = inj_q ? {mem_q[2:0], mem_q[3]} : mem_q;
`else
    assign jogada = mem_q;
`endif

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:       if (comecar) prox = PULSO_INICIAR;
            PULSO_INICIAR: if (cnt == CW'(START_CYCLES - 1)) prox = ESPERA;
            ESPERA:        if (cnt == CW'(GAP_CYCLES - 1)) prox = APLICA;
            APLICA: begin
                if (!mem_onehot)                        prox = ERRO_ENTRADA;
                else if (cnt == CW'(HOLD_CYCLES - 1))   prox = INTERVALO;
            end
            INTERVALO:     if (cnt == CW'(GAP_CYCLES - 1)) prox = VERIFICA;
            VERIFICA: begin
                if (pronto && errou)                    prox = FIM_ERRO;
                else if (pronto && acertou)             prox = FIM_OK;
                else if (jog_q == 5'(N_JOGADAS))        prox = FIM_ERRO;
                else                                    prox = APLICA;
            end
            FIM_OK, FIM_ERRO, ERRO_ENTRADA: if (comecar) prox = PULSO_INICIAR;
            default:       prox = INICIAL;
        endcase
        // A reported error aborts the game from any active play phase
        if (errou && (estado inside {ESPERA, APLICA, INTERVALO, VERIFICA}))
            prox = FIM_ERRO;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            cnt    <= '0;
            mem_q  <= 4'b0000;
            jog_q  <= 5'd0;
`ifdef JOGADOR_INJETA_ERRO_EN
            inj_q  <= 1'b0;
`endif
        end else begin
            estado <= prox;
            if (prox != estado)
                cnt <= '0;
            else if (cnt != CW'(MAX_C))
                cnt <= cnt + 1'b1;

            // The play is captured once per APLICA entry and held for the whole phase
            if (prox == APLICA && estado != APLICA) begin
                mem_q <= memoria;
`ifdef JOGADOR_INJETA_ERRO_EN
                inj_q <= (erro_rodada == jog_q);
`endif
            end

            if (prox == PULSO_INICIAR && estado != PULSO_INICIAR)
                jog_q <= 5'd0;
            else if (prox == INTERVALO && estado == APLICA && jog_q != 5'(N_JOGADAS))
                jog_q <= jog_q + 5'd1;
        end
    end

    assign iniciar        = (estado == PULSO_INICIAR);
    assign chaves         = (estado == APLICA) ? jogada : 4'b0000;
    assign ocupado        = !(estado inside {INICIAL, FIM_OK, FIM_ERRO, ERRO_ENTRADA});
    assign fim_ok         = (estado == FIM_OK);
    assign fim_erro       = (estado == FIM_ERRO) || (estado == ERRO_ENTRADA);
    assign jogadas_feitas = jog_q;
    assign db_estado      = estado;

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter HOLD_CYCLES, default 10: clock cycles each play is held on chaves.
REQ-002 Parameter GAP_CYCLES, default 10: clock cycles chaves is held at 0000 between plays.
REQ-003 Parameter START_CYCLES, default 5: clock cycles iniciar is held high.
REQ-004 Parameter N_JOGADAS, default 16, range 1..31: plays issued per game.
REQ-005 clock  in  1  system clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 comecar  in  1  starts one automatic game; sampled only in state INICIAL.
REQ-008 memoria  in  4  expected play from the game circuit, one-hot.
REQ-009 acertou / errou / pronto  in  1 each  game-circuit result flags.
REQ-010 iniciar  out  1  start pulse to the game circuit.
REQ-011 chaves  out  4  play driven into the game circuit.
REQ-012 ocupado  out  1  high in every state except INICIAL, FIM_OK and FIM_ERRO.
REQ-013 fim_ok / fim_erro  out  1 each  terminal-result flags.
REQ-014 jogadas_feitas  out  5  count of completed plays.
REQ-015 db_estado  out  4  current state encoding.

Function
REQ-016 States and encodings: INICIAL=0, PULSO_INICIAR=1, ESPERA=2, APLICA=3, INTERVALO=4, VERIFICA=5, FIM_OK=6, FIM_ERRO=7, ERRO_ENTRADA=8; ERRO_ENTRADA reports as FIM_ERRO on outputs; db_estado shows 8.
REQ-017 INICIAL -> PULSO_INICIAR when comecar=1; iniciar=1 for exactly START_CYCLES cycles, then -> ESPERA.
REQ-018 ESPERA lasts GAP_CYCLES cycles with chaves=0000, then -> APLICA.
REQ-019 On entry to APLICA, memoria is registered once and chaves is driven from that register for exactly HOLD_CYCLES cycles; changes on memoria during the hold are ignored.
REQ-020 If the registered memoria is not one-hot (including 0000), the state goes to ERRO_ENTRADA on the next cycle and chaves returns to 0000.
REQ-021 APLICA -> INTERVALO after the hold; chaves=0000 for GAP_CYCLES cycles; jogadas_feitas increments by 1 on the INTERVALO entry edge.
REQ-022 INTERVALO -> VERIFICA; in VERIFICA, evaluation follows this priority order:
  - pronto=1 and errou=1 -> FIM_ERRO.
  - pronto=1 and acertou=1 -> FIM_OK.
  - jogadas_feitas==N_JOGADAS -> FIM_ERRO (game failed to finish).
  - otherwise -> APLICA.
REQ-023 errou=1 sampled in any state from ESPERA through VERIFICA forces the next state to FIM_ERRO, with chaves=0000 the same cycle.
REQ-024 FIM_OK, FIM_ERRO and ERRO_ENTRADA hold their outputs until comecar=1, which clears jogadas_feitas and -> PULSO_INICIAR.
REQ-025 comecar while ocupado=1 is ignored.
REQ-026 jogadas_feitas saturates at N_JOGADAS and never wraps.
REQ-027 Phase counters are sized ceil(log2(max(HOLD,GAP,START)+1)) and reload to 0 on every state change.
REQ-028 All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Reset
REQ-029 reset=0 asynchronously forces INICIAL, iniciar=0, chaves=0000, ocupado=0, fim_ok=0, fim_erro=0, jogadas_feitas=0, db_estado=0, and clears all counters and the memoria register.
REQ-030 Reset asserted mid-game (e.g. during APLICA) drops chaves to 0000 immediately, with no clock edge required.
REQ-031 The first active state transition occurs on the first rising edge after reset deasserts, and only if comecar=1.

Configuration
REQ-032 Macro JOGADOR_INJETA_ERRO_EN compiled in: adds input erro_rodada[4:0]; on the play whose index (0-based, = jogadas_feitas at APLICA entry) equals erro_rodada, chaves is driven with the registered memoria rotated left by one bit (deliberate wrong play).
REQ-033 Without JOGADOR_INJETA_ERRO_EN: the erro_rodada port is absent and every play equals the registered memoria.

Verification
REQ-034 Reset then comecar=1 for 1 cycle -> iniciar high exactly 5 cycles, chaves=0000 for 10 cycles, then chaves=memoria for 10 cycles.
REQ-035 memoria sequence 0001,0010,0100; game model asserts pronto+acertou after the 3rd play -> fim_ok=1, jogadas_feitas=3, db_estado=6.
REQ-036 memoria=0011 at APLICA entry -> chaves=0000 next cycle, fim_erro=1, db_estado=8.
REQ-037 errou pulsed high during the 2nd hold -> chaves=0000 next cycle, fim_erro=1, jogadas_feitas=1.
REQ-038 reset driven low mid-APLICA between clock edges -> chaves=0000 and db_estado=0 before the next edge.
REQ-039 With JOGADOR_INJETA_ERRO_EN, erro_rodada=1, memoria=0100 on the 2nd play -> chaves=1000 for 10 cycles.
